axis_frame_gen_chk: RTL and testbench
=====================================

// Module: axis_frame_gen_chk
// PURPOSE
//  Test-harness AXI4-Stream frame source plus loop-back checker, the far end of the stream
//  accelerators' slave/master pair. It drives FRAME_WORDS-word frames of running-counter data
//  into the DUT slave port and checks the frames returned on the DUT master port.
//  It counts data/TLAST errors and flags a stalled DUT by timeout. Used on-chip and in sim.
// PARAMETERS
//  DATA_WIDTH   32     stream data width
//  FRAME_WORDS  8      words per frame (>=2); TLAST on word FRAME_WORDS-1
//  TIMEOUT      1024   max cycles in WAIT_RX before abort
// PORTS
//  axi_clk        in   1           single clock, all logic rising-edge
//  axi_reset      in   1           asynchronous, active-high reset
//  start          in   1           1-cycle pulse: begin run (ignored while busy)
//  frame_count    in   16          frames per run, sampled on start
//  seed           in   DATA_WIDTH  first data word, sampled on start
//  m_axis_valid   out  1           TX stream to DUT slave
//  m_axis_data    out  DATA_WIDTH
//  m_axis_last    out  1
//  m_axis_ready   in   1
//  s_axis_valid   in   1           RX stream from DUT master
//  s_axis_data    in   DATA_WIDTH
//  s_axis_last    in   1
//  s_axis_ready   out  1
//  busy           out  1           run in progress
//  done           out  1           1-cycle pulse at end of run
//  timeout        out  1           sticky until next start: WAIT_RX exceeded TIMEOUT
//  err_count      out  16          saturating error count for run
//  rx_frames      out  16          frames closed by checker this run
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, all counters 0; reset mid-run drops m_axis_valid at once.
//  Data rule: TX word k of frame f = seed + f*FRAME_WORDS + k, mod 2^DATA_WIDTH (wraps freely).
//  FSM: IDLE -> start & frame_count!=0 -> SEND. IDLE -> start & frame_count==0 -> DONE.
//   SEND: valid=1; word advances only on valid&ready; last=1 on word FRAME_WORDS-1.
//     After last accepted -> WAIT_RX (valid=0 next cycle).
//   WAIT_RX: waits until rx_frames == tx_frames. If tx_frames==frame_count -> DONE,
//     else -> SEND. Cycle counter > TIMEOUT -> timeout=1 and DONE.
//   DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
//   err_count/rx_frames/timeout clear on an accepted start.
//  Latency: start in cycle 0 -> busy=1, m_axis_valid=1, data=seed in cycle 1 (registered).
//  AXI rules: once valid=1, data/last held stable until ready; valid never drops mid-frame.
//  s_axis_ready = busy (SEND or WAIT_RX); 0 in IDLE/DONE, so stray RX words are not accepted.
//  Checker, per accepted RX word (index i, expected word E):
//   data!=E -> +1 error. Expected advances by 1 after each accepted word.
//   last=1, i<FRAME_WORDS-1 -> +1 error (early).
//   last=0, i==FRAME_WORDS-1 -> +1 error (late). Frame closes anyway.
//   On any frame close: rx_frames+1, i=0, E=seed+rx_frames_new*FRAME_WORDS (resync).
//   Data and TLAST errors in one word count 2. err_count saturates at 16'hFFFF.
//  Simultaneous: RX frame close in same cycle as WAIT_RX check uses the updated rx_frames.
//   start coincident with done is ignored.
// STRUCTURE
//  Package axis_gen_pkg: FSM state enum (IDLE, SEND, WAIT_RX, DONE), counter widths,
//   clog2 function for FRAME_WORDS/TIMEOUT counter widths.
//  Sub-module axis_stream_checker: RX index, expected-word generator, error/frame counters.
//   Inputs are seed, clear and enable. TX FSM and word generator stay in top level.
// TESTING
//  1. seed=0x10, frame_count=1, ready=1, loop-back -> TX 0x10..0x17, last on 0x17,
//     err=0, rx_frames=1, done pulse.
//  2. ready toggling 1/0 each cycle -> data/last stable while stalled, 8 words sent once.
//  3. seed=0xFFFFFFFE, frame_count=2 -> words wrap to 0x0..; err=0, rx_frames=2.
//  4. Return path corrupts word 3 (xor 1) and asserts last on word 5 -> err_count=2.
//     Next frame resyncs and checks clean.
//  5. DUT never returns data -> timeout=1 after TIMEOUT+1 cycles in WAIT_RX.
//     done pulse, busy=0.
//  6. axi_reset mid-SEND -> valid/busy 0 immediately. start with frame_count=0 after reset
//     -> done in cycle 1, no traffic.

Source files
------------

// File: rtl/axis_gen_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream frame generator/checker.
package axis_gen_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      WAIT_RX = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Bits needed to hold values 0..value-1; never less than 1.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/axis_stream_checker.sv
// Loop-back checker: tracks word index and expected data of returned frames,
// counts data/TLAST errors and closed frames.
module axis_stream_checker
   import axis_gen_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int FRAME_WORDS = 8
) (
   input  logic                  axi_clk,
   input  logic                  axi_reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_last,
   output logic [CNT_W-1:0]      err_count,
   output logic [CNT_W-1:0]      rx_frames,
   output logic [CNT_W-1:0]      rx_frames_nxt
);

   localparam int IDX_W = clog2(FRAME_WORDS);

   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] exp_word;
   logic [DATA_WIDTH-1:0] frame_base;
   logic [DATA_WIDTH-1:0] frame_base_nxt;
   logic                  accept;
   logic                  at_end;
   logic                  data_err;
   logic                  tlast_err;
   logic                  close;
   logic [1:0]            err_inc;
   logic [CNT_W:0]        err_sum;
   logic [CNT_W-1:0]      err_nxt;

   // Per-word error classification and saturating error update.
   always_comb begin
      accept         = enable & rx_valid;
      at_end         = (idx == IDX_W'(FRAME_WORDS - 1));
      data_err       = (rx_data != exp_word);
      tlast_err      = rx_last ? !at_end : at_end;
      close          = accept & (rx_last | at_end);
      err_inc        = {1'b0, data_err} + {1'b0, tlast_err};
      err_sum        = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, err_inc};
      err_nxt        = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
      frame_base_nxt = frame_base + DATA_WIDTH'(FRAME_WORDS);
      rx_frames_nxt  = rx_frames + {{(CNT_W-1){1'b0}}, close};
   end

   // Checker state; a closed frame (early, on time or late) resyncs expected data.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         idx        <= '0;
         exp_word   <= '0;
         frame_base <= '0;
         err_count  <= '0;
         rx_frames  <= '0;
      end else if (clear) begin
         idx        <= '0;
         exp_word   <= seed;
         frame_base <= seed;
         err_count  <= '0;
         rx_frames  <= '0;
      end else if (accept) begin
         err_count <= err_nxt;
         rx_frames <= rx_frames_nxt;
         if (close) begin
            idx        <= '0;
            frame_base <= frame_base_nxt;
            exp_word   <= frame_base_nxt;
         end else begin
            idx      <= idx + IDX_W'(1);
            exp_word <= exp_word + DATA_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/axis_frame_gen_chk.sv
// AXI4-Stream frame source with loop-back checker and stall timeout.
//
//   state   | meaning
//   IDLE    | waiting for start
//   SEND    | driving a frame of counter data, valid held until last accepted
//   WAIT_RX | waiting for the returned frame count to catch up, timer running
//   DONE    | one-cycle done pulse, back to IDLE
module axis_frame_gen_chk
   import axis_gen_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int FRAME_WORDS = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                  axi_clk,
   input  logic                  axi_reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      frame_count,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic                  m_axis_valid,
   output logic [DATA_WIDTH-1:0] m_axis_data,
   output logic                  m_axis_last,
   input  logic                  m_axis_ready,
   input  logic                  s_axis_valid,
   input  logic [DATA_WIDTH-1:0] s_axis_data,
   input  logic                  s_axis_last,
   output logic                  s_axis_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [CNT_W-1:0]      err_count,
   output logic [CNT_W-1:0]      rx_frames
);

   localparam int IDX_W = clog2(FRAME_WORDS);
   localparam int TMO_W = clog2(TIMEOUT + 1);

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] tx_data;
   logic [IDX_W-1:0]      word_idx;
   logic [CNT_W-1:0]      tx_frames;
   logic [CNT_W-1:0]      frame_count_q;
   logic [TMO_W-1:0]      tmo_cnt;
   logic [CNT_W-1:0]      rx_frames_nxt;
   logic                  start_acc;
   logic                  tx_hs;
   logic                  word_end;
   logic                  rx_match;
   logic                  tmo_hit;

   assign m_axis_valid = (state == SEND);
   assign m_axis_data  = tx_data;
   assign m_axis_last  = (state == SEND) & word_end;
   assign busy         = (state == SEND) | (state == WAIT_RX);
   assign s_axis_ready = busy;
   assign done         = (state == DONE);

   // Next-state decode; the frame match uses the checker's post-update frame count.
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      tx_hs     = 1'b0;
      word_end  = (word_idx == IDX_W'(FRAME_WORDS - 1));
      rx_match  = (rx_frames_nxt == tx_frames);
      tmo_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = (frame_count != '0) ? SEND : DONE;
            end
         end
         SEND: begin
            tx_hs = m_axis_ready;
            if (m_axis_ready && word_end) state_nxt = WAIT_RX;
         end
         WAIT_RX: begin
            if (rx_match) begin
               state_nxt = (tx_frames == frame_count_q) ? DONE : SEND;
            end else if (tmo_cnt == '0) begin
               tmo_hit   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) state <= IDLE;
      else           state <= state_nxt;
   end

   // TX word generator, frame counters and WAIT_RX down-counter timer.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         tx_data       <= '0;
         word_idx      <= '0;
         tx_frames     <= '0;
         frame_count_q <= '0;
         tmo_cnt       <= '0;
         timeout       <= 1'b0;
      end else begin
         if (start_acc) begin
            tx_data       <= seed;
            word_idx      <= '0;
            tx_frames     <= '0;
            frame_count_q <= frame_count;
            timeout       <= 1'b0;
         end
         if (tx_hs) begin
            tx_data <= tx_data + DATA_WIDTH'(1);
            if (word_end) begin
               word_idx  <= '0;
               tx_frames <= tx_frames + CNT_W'(1);
               tmo_cnt   <= TMO_W'(TIMEOUT);
            end else begin
               word_idx <= word_idx + IDX_W'(1);
            end
         end
         if (state == WAIT_RX && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
         if (tmo_hit) timeout <= 1'b1;
      end
   end

   axis_stream_checker #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FRAME_WORDS (FRAME_WORDS)
   ) u_checker (
      .axi_clk       (axi_clk),
      .axi_reset     (axi_reset),
      .clear         (start_acc),
      .enable        (s_axis_ready),
      .seed          (seed),
      .rx_valid      (s_axis_valid),
      .rx_data       (s_axis_data),
      .rx_last       (s_axis_last),
      .err_count     (err_count),
      .rx_frames     (rx_frames),
      .rx_frames_nxt (rx_frames_nxt)
   );

endmodule

// File: tb/tb_axis_frame_gen_chk.sv
// Scoreboard bench for axis_frame_gen_chk with a bench-side loop-back path.
module tb_axis_frame_gen_chk;

   localparam int DW  = 32;
   localparam int FW  = 8;
   localparam int TMO = 1024;

   logic          axi_clk;
   logic          axi_reset;
   logic          start;
   logic [15:0]   frame_count;
   logic [DW-1:0] seed;
   logic          m_axis_valid;
   logic [DW-1:0] m_axis_data;
   logic          m_axis_last;
   logic          m_axis_ready;
   logic          s_axis_valid;
   logic [DW-1:0] s_axis_data;
   logic          s_axis_last;
   logic          s_axis_ready;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [15:0]   err_count;
   logic [15:0]   rx_frames;

   int n_vec;
   int n_err;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } word_t;

   word_t sbq[$];
   word_t rxq[$];

   axis_frame_gen_chk #(
      .DATA_WIDTH  (DW),
      .FRAME_WORDS (FW),
      .TIMEOUT     (TMO)
   ) dut (
      .axi_clk      (axi_clk),
      .axi_reset    (axi_reset),
      .start        (start),
      .frame_count  (frame_count),
      .seed         (seed),
      .m_axis_valid (m_axis_valid),
      .m_axis_data  (m_axis_data),
      .m_axis_last  (m_axis_last),
      .m_axis_ready (m_axis_ready),
      .s_axis_valid (s_axis_valid),
      .s_axis_data  (s_axis_data),
      .s_axis_last  (s_axis_last),
      .s_axis_ready (s_axis_ready),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .err_count    (err_count),
      .rx_frames    (rx_frames)
   );

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // rdy_mode: 0 always ready, 1 toggling. lb_mode: 0 no return, 1 clean, 2 corrupt frame 0.
   task automatic run(input logic [DW-1:0] sd, input int fc, input int rdy_mode,
                      input int lb_mode, input int exp_err, input int exp_rx,
                      input int exp_to, input int exp_wait);
      int     tx_cnt;
      int     wait_cyc;
      bit     waiting;
      bit     seen_done;
      logic   prev_stall;
      logic [DW-1:0] prev_d;
      logic   prev_l;
      word_t  w;
      word_t  e;
      tx_cnt = 0; wait_cyc = 0; waiting = 0; seen_done = 0;
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      sbq.delete();
      rxq.delete();
      for (int f = 0; f < fc; f++)
         for (int k = 0; k < FW; k++) begin
            e.d = sd + DW'(f * FW + k);
            e.l = (k == FW - 1);
            sbq.push_back(e);
         end
      @(negedge axi_clk);
      seed = sd; frame_count = 16'(fc); start = 1'b1;
      @(negedge axi_clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 0) begin
            chk("lat_busy", busy, (fc != 0));
            chk("lat_valid", m_axis_valid, (fc != 0));
            chk("lat_done", done, (fc == 0));
            if (fc != 0) chk("lat_data", m_axis_data, sd);
         end
         m_axis_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         if (prev_stall) begin
            chk("stall_valid", m_axis_valid, 1'b1);
            chk("stall_data", m_axis_data, prev_d);
            chk("stall_last", m_axis_last, prev_l);
         end
         if (waiting && busy && !m_axis_valid) wait_cyc++;
         if (m_axis_valid && m_axis_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_extra_word", m_axis_data, 32'hDEAD_BEEF);
            end else begin
               e = sbq.pop_front();
               chk("tx_data", m_axis_data, e.d);
               chk("tx_last", m_axis_last, e.l);
            end
            w.d = m_axis_data;
            w.l = m_axis_last;
            if (lb_mode == 2 && tx_cnt < FW) begin
               if (tx_cnt == 3) w.d = w.d ^ 32'h1;
               if (tx_cnt == 5) w.l = 1'b1;
               if (tx_cnt <= 5) rxq.push_back(w);
            end else if (lb_mode != 0) begin
               rxq.push_back(w);
            end
            if (m_axis_last) waiting = 1;
            tx_cnt++;
         end
         prev_stall = m_axis_valid && !m_axis_ready;
         prev_d = m_axis_data;
         prev_l = m_axis_last;
         if (rxq.size() != 0) begin
            s_axis_valid = 1'b1;
            s_axis_data  = rxq[0].d;
            s_axis_last  = rxq[0].l;
            if (s_axis_ready) void'(rxq.pop_front());
         end else begin
            s_axis_valid = 1'b0;
            s_axis_data  = '0;
            s_axis_last  = 1'b0;
         end
         if (done) begin
            seen_done = 1;
            break;
         end
         @(negedge axi_clk);
      end
      chk("done_seen", seen_done, 1'b1);
      chk("busy_end", busy, 1'b0);
      chk("err_count", err_count, exp_err);
      chk("rx_frames", rx_frames, exp_rx);
      chk("timeout", timeout, exp_to);
      chk("sb_left", sbq.size(), 0);
      if (exp_wait >= 0) chk("wait_cycles", wait_cyc, exp_wait);
      s_axis_valid = 1'b0;
      rxq.delete();
      @(negedge axi_clk);
      chk("done_pulse_width", done, 1'b0);
      chk("timeout_sticky", timeout, exp_to);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      axi_reset = 1'b1; start = 1'b0; frame_count = '0; seed = '0;
      m_axis_ready = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0;
      repeat (3) @(negedge axi_clk);
      chk("rst_valid", m_axis_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_data", m_axis_data, '0);
      chk("rst_err", err_count, '0);
      axi_reset = 1'b0;
      @(negedge axi_clk);

      run(32'h10, 1, 0, 1, 0, 1, 0, -1);
      run(32'h100, 1, 1, 1, 0, 1, 0, -1);
      run(32'hFFFF_FFFE, 2, 0, 1, 0, 2, 0, -1);
      run(32'h2000, 2, 0, 2, 2, 2, 0, -1);
      run(32'h300, 1, 0, 0, 0, 0, 1, TMO + 1);

      @(negedge axi_clk);
      seed = 32'h5; frame_count = 16'd3; start = 1'b1; m_axis_ready = 1'b0;
      @(negedge axi_clk);
      start = 1'b0;
      repeat (3) @(negedge axi_clk);
      chk("pre_rst_valid", m_axis_valid, 1'b1);
      #2 axi_reset = 1'b1;
      #1;
      chk("midrst_valid", m_axis_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_timeout", timeout, 1'b0);
      @(negedge axi_clk);
      axi_reset = 1'b0;
      run(32'h0, 0, 0, 0, 0, 0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
